// File: rtl/rf_stage_ilk_pkg.sv
// Shared encodings for the mips789 register-fetch stage: interlock states,
// forward/compare/destination selects and the NOP word.
package rf_stage_ilk_pkg;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_LU_STALL = 1'b1
    } ilk_state_e;

    typedef enum logic [1:0] {
        FW_BANK     = 2'd0,
        FW_ALU      = 2'd1,
        FW_MEM      = 2'd2,
        FW_BANK_ALT = 2'd3
    } fw_ctl_e;

    typedef enum logic [2:0] {
        CMP_EQ  = 3'd0,
        CMP_NE  = 3'd1,
        CMP_LTZ = 3'd2,
        CMP_LEZ = 3'd3,
        CMP_GTZ = 3'd4,
        CMP_GEZ = 3'd5,
        CMP_F6  = 3'd6,
        CMP_F7  = 3'd7
    } cmp_ctl_e;

    typedef enum logic [1:0] {
        RD_RD  = 2'd0,
        RD_RT  = 2'd1,
        RD_R31 = 2'd2,
        RD_R0  = 2'd3
    } rd_sel_e;

    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam int unsigned RS_LSB   = 21;
    localparam int unsigned RT_LSB   = 16;
    localparam int unsigned RD_LSB   = 11;
    localparam int unsigned LINK_REG = 31;

endpackage

// File: rtl/rf_bank.sv
// Register bank: NREG x DATA_W, one write port, two read ports latched under rd_en_i.
// Optional macro RF_WR_BYPASS_EN makes a same-edge write visible to the read latches.
module rf_bank
    import rf_stage_ilk_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NREG     = 32,
    parameter int unsigned RST_BANK = 1,
    localparam int unsigned AW      = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     rd_a_addr_i,
    input  logic [AW-1:0]     rd_b_addr_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rd_a_o,
    output logic [DATA_W-1:0] rd_b_o
);

    logic [DATA_W-1:0] r_mem [NREG];
    logic [DATA_W-1:0] r_rd_a, r_rd_b;
    logic [DATA_W-1:0] w_rd_a, w_rd_b;
    logic              w_wr;

    // r0 is never written, so its storage may stay unreset when RST_BANK=0
    assign w_wr = we_i && (waddr_i != '0);

    generate
        if (RST_BANK != 0) begin : g_rst_bank
            always_ff @(posedge clk or posedge rst_i) begin
                if (rst_i) begin
                    for (int unsigned i = 0; i < NREG; i++) r_mem[i] <= '0;
                end else if (w_wr) begin
                    r_mem[waddr_i] <= wdata_i;
                end
            end
        end else begin : g_ram_bank
            always_ff @(posedge clk) begin
                if (w_wr) r_mem[waddr_i] <= wdata_i;
            end
        end
    endgenerate

    always_comb begin
        w_rd_a = (rd_a_addr_i == '0) ? '0 : r_mem[rd_a_addr_i];
        w_rd_b = (rd_b_addr_i == '0) ? '0 : r_mem[rd_b_addr_i];
`ifdef RF_WR_BYPASS_EN
        if (w_wr && (waddr_i == rd_a_addr_i)) w_rd_a = wdata_i;
        if (w_wr && (waddr_i == rd_b_addr_i)) w_rd_b = wdata_i;
`endif
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_rd_a <= '0;
            r_rd_b <= '0;
        end else if (rd_en_i) begin
            r_rd_a <= w_rd_a;
            r_rd_b <= w_rd_b;
        end
    end

    assign rd_a_o = r_rd_a;
    assign rd_b_o = r_rd_b;

endmodule

// File: rtl/rf_stage_ilk.sv
// mips789 register-fetch stage: IR, early-addressed bank, forwarding, branch compare
// and load-use interlock. RF_WR_BYPASS_EN selects write-through in the bank read latches.
module rf_stage_ilk
    import rf_stage_ilk_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NREG     = 32,
    parameter int unsigned RST_BANK = 1,
    localparam int unsigned AW      = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              pause,
    input  logic [31:0]       ins_i,
    input  logic              ins_clr,
    input  logic              ins_cls,
    input  logic              is_load_i,
    input  logic              wb_we_i,
    input  logic [AW-1:0]     wb_addr_i,
    input  logic [DATA_W-1:0] wb_din_i,
    input  logic [DATA_W-1:0] fw_alu_i,
    input  logic [DATA_W-1:0] fw_mem_i,
    input  logic [1:0]        fw_rs_ctl,
    input  logic [1:0]        fw_rt_ctl,
    input  logic [2:0]        cmp_ctl_i,
    input  logic [1:0]        rd_sel_i,
    output logic [31:0]       ins_o,
    output logic [AW-1:0]     rs_n_o,
    output logic [AW-1:0]     rt_n_o,
    output logic [AW-1:0]     rd_index_o,
    output logic [DATA_W-1:0] rs_o,
    output logic [DATA_W-1:0] rt_o,
    output logic              cmp_res_o,
    output logic              stall_o,
    output logic              bubble_o
);

    logic [31:0]       r_ir;
    ilk_state_e        r_state;
    logic              r_ld_v;
    logic [AW-1:0]     r_ld_dst;
    logic              w_hazard, w_stall, w_ir_adv;
    logic [AW-1:0]     w_rs_addr, w_rt_addr;
    logic [DATA_W-1:0] w_bank_rs, w_bank_rt;

    assign ins_o  = r_ir;
    assign rs_n_o = r_ir[RS_LSB +: AW];
    assign rt_n_o = r_ir[RT_LSB +: AW];

    assign w_hazard = (r_state == ST_RUN) && r_ld_v && (r_ld_dst != '0) &&
                      ((r_ld_dst == rs_n_o) || (r_ld_dst == rt_n_o));
    assign w_stall  = w_hazard && !pause;
    assign stall_o  = w_stall;
    assign bubble_o = w_stall;

    // A flush also moves the read latches, addressed at r0 so they match the NOP
    assign w_ir_adv  = !pause && (ins_clr || !(ins_cls || w_stall));
    assign w_rs_addr = ins_clr ? '0 : ins_i[RS_LSB +: AW];
    assign w_rt_addr = ins_clr ? '0 : ins_i[RT_LSB +: AW];

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_ir <= NOP;
        end else if (!pause) begin
            if (ins_clr)                   r_ir <= NOP;
            else if (!(ins_cls || w_stall)) r_ir <= ins_i;
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= ST_RUN;
            r_ld_v   <= 1'b0;
            r_ld_dst <= '0;
        end else if (!pause) begin
            if (w_stall) begin
                r_state <= ST_LU_STALL;
                r_ld_v  <= 1'b0;
            end else begin
                r_state <= ST_RUN;
                if (w_ir_adv) begin
                    r_ld_v   <= is_load_i;
                    r_ld_dst <= rt_n_o;
                end
            end
        end
    end

    rf_bank #(
        .DATA_W  (DATA_W),
        .NREG    (NREG),
        .RST_BANK(RST_BANK)
    ) u_bank (
        .clk        (clk),
        .rst_i      (rst_i),
        .rd_en_i    (w_ir_adv),
        .rd_a_addr_i(w_rs_addr),
        .rd_b_addr_i(w_rt_addr),
        .we_i       (wb_we_i),
        .waddr_i    (wb_addr_i),
        .wdata_i    (wb_din_i),
        .rd_a_o     (w_bank_rs),
        .rd_b_o     (w_bank_rt)
    );

    function automatic logic [DATA_W-1:0] fw_mux(input logic [1:0] ctl,
                                                 input logic [DATA_W-1:0] bank,
                                                 input logic [DATA_W-1:0] alu,
                                                 input logic [DATA_W-1:0] mem);
        case (fw_ctl_e'(ctl))
            FW_ALU:  return alu;
            FW_MEM:  return mem;
            default: return bank;
        endcase
    endfunction

    assign rs_o = fw_mux(fw_rs_ctl, w_bank_rs, fw_alu_i, fw_mem_i);
    assign rt_o = fw_mux(fw_rt_ctl, w_bank_rt, fw_alu_i, fw_mem_i);

    always_comb begin
        cmp_res_o = 1'b0;
        case (cmp_ctl_e'(cmp_ctl_i))
            CMP_EQ:  cmp_res_o = (rs_o == rt_o);
            CMP_NE:  cmp_res_o = (rs_o != rt_o);
            CMP_LTZ: cmp_res_o = rs_o[DATA_W-1];
            CMP_LEZ: cmp_res_o = rs_o[DATA_W-1] || (rs_o == '0);
            CMP_GTZ: cmp_res_o = !rs_o[DATA_W-1] && (rs_o != '0);
            CMP_GEZ: cmp_res_o = !rs_o[DATA_W-1];
            default: cmp_res_o = 1'b0;
        endcase
    end

    always_comb begin
        rd_index_o = '0;
        case (rd_sel_e'(rd_sel_i))
            RD_RD:   rd_index_o = r_ir[RD_LSB +: AW];
            RD_RT:   rd_index_o = rt_n_o;
            RD_R31:  rd_index_o = AW'(LINK_REG);
            default: rd_index_o = '0;
        endcase
    end

endmodule
